heap_sift_stage: RTL and testbench

HEAP_SIFT_STAGE -- requirements
Module: heap_sift_stage

---
 rtl/heap_sift_stage.sv | 137 +++++++++++++
 tb/tb_heap_sift_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_sift_stage.sv
// rtl/heap_sift_stage.sv - one level of a pipelined min/max heap insert: compare, swap, push down
module heap_sift_stage #(
  parameter int CNT_SIZE      = 20,
  parameter int ADDR_SIZE     = 28,
  parameter int TOTAL_LEVEL   = 6,
  parameter int CURRENT_LEVEL = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_LEVEL-1:0] in_index,
  input  logic [CNT_SIZE-1:0]    in_cnt,
  input  logic [ADDR_SIZE-1:0]   in_addr,
  input  logic [TOTAL_LEVEL-1:0] in_path,
  input  logic [CNT_SIZE-1:0]    stored_cnt  [0:2**(CURRENT_LEVEL-1)-1],
  input  logic [ADDR_SIZE-1:0]   stored_addr [0:2**(CURRENT_LEVEL-1)-1],
  output logic                   write_en,
  output logic [TOTAL_LEVEL-1:0] write_index,
  output logic [CNT_SIZE-1:0]    write_cnt,
  output logic [ADDR_SIZE-1:0]   write_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_LEVEL-1:0] out_index,
  output logic [CNT_SIZE-1:0]    out_cnt,
  output logic [ADDR_SIZE-1:0]   out_addr,
  output logic [TOTAL_LEVEL-1:0] out_path,
  output logic                   err_index,
  output logic [15:0]            evict_cnt
);

  localparam int NUM_CNT = 2**(CURRENT_LEVEL-1);
  localparam int SEL_W   = (CURRENT_LEVEL > 1) ? CURRENT_LEVEL - 1 : 1;
  localparam logic [TOTAL_LEVEL:0] NUM_CNT_W = (TOTAL_LEVEL+1)'(NUM_CNT);
  localparam bit IS_LAST = (CURRENT_LEVEL == TOTAL_LEVEL);

  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, FWD = 2'd2} state_t;

  state_t state_q, state_d;

  logic [TOTAL_LEVEL-1:0] idx_q;
  logic [CNT_SIZE-1:0]    cnt_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [TOTAL_LEVEL-1:0] path_q;
  logic [TOTAL_LEVEL-1:0] out_index_q;
  logic [CNT_SIZE-1:0]    out_cnt_q;
  logic [ADDR_SIZE-1:0]   out_addr_q;
  logic [TOTAL_LEVEL-1:0] out_path_q;
  logic                   err_q;
  logic [15:0]            evict_q;

  logic                   bad_idx;
  logic                   accept;
  logic [SEL_W-1:0]       sel;
  logic [CNT_SIZE-1:0]    s_cnt;
  logic [ADDR_SIZE-1:0]   s_addr;
  logic                   slot_empty;
  logic                   in_wins;
  logic                   do_fwd;

  assign bad_idx    = ({1'b0, in_index} >= NUM_CNT_W);
  assign accept     = in_valid && (state_q == IDLE);
  assign sel        = idx_q[SEL_W-1:0];
  assign s_cnt      = stored_cnt[sel];
  assign s_addr     = stored_addr[sel];
  assign slot_empty = (s_cnt == '0);
  assign in_wins    = (cnt_q > s_cnt);
  // An occupied slot always pushes something down: either the old occupant or the newcomer.
  assign do_fwd     = (state_q == CMP) && !slot_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid && !bad_idx) state_d = CMP;
      CMP:  state_d = (slot_empty || IS_LAST) ? IDLE : FWD;
      FWD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == FWD);
    write_en  = (state_q == CMP) && (slot_empty || in_wins);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      path_q      <= '0;
      out_index_q <= '0;
      out_cnt_q   <= '0;
      out_addr_q  <= '0;
      out_path_q  <= '0;
      err_q       <= 1'b0;
      evict_q     <= '0;
    end else begin
      err_q <= accept && bad_idx;
      if (accept && !bad_idx) begin
        idx_q  <= in_index;
        cnt_q  <= in_cnt;
        addr_q <= in_addr;
        path_q <= in_path;
      end
      if (do_fwd && !IS_LAST) begin
        out_index_q <= {idx_q[TOTAL_LEVEL-2:0], path_q[CURRENT_LEVEL-1]};
        out_cnt_q   <= in_wins ? s_cnt  : cnt_q;
        out_addr_q  <= in_wins ? s_addr : addr_q;
        out_path_q  <= path_q;
      end
      if (do_fwd && IS_LAST && (evict_q != 16'hFFFF)) begin
        evict_q <= evict_q + 16'd1;
      end
    end
  end

  assign write_index = idx_q;
  assign write_cnt   = cnt_q;
  assign write_addr  = addr_q;
  assign out_index   = out_index_q;
  assign out_cnt     = out_cnt_q;
  assign out_addr    = out_addr_q;
  assign out_path    = out_path_q;
  assign err_index   = err_q;
  assign evict_cnt   = evict_q;

endmodule

// File: tb/tb_heap_sift_stage.sv
// tb/tb_heap_sift_stage.sv - directed checks of a mid level (3) and a last level (6) sift stage
module tb_heap_sift_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        va = 1'b0, vb = 1'b0;
  logic [5:0]  in_index = '0, in_path = '0;
  logic [19:0] in_cnt = '0;
  logic [27:0] in_addr = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_write_en, a_out_valid, a_err;
  logic [5:0]  a_write_index, a_out_index, a_out_path;
  logic [19:0] a_write_cnt, a_out_cnt;
  logic [27:0] a_write_addr, a_out_addr;
  logic [15:0] a_evict;
  logic [19:0] sa_cnt [0:3];
  logic [27:0] sa_addr [0:3];

  logic        b_in_ready, b_write_en, b_out_valid, b_err;
  logic [5:0]  b_write_index, b_out_index, b_out_path;
  logic [19:0] b_write_cnt, b_out_cnt;
  logic [27:0] b_write_addr, b_out_addr;
  logic [15:0] b_evict;
  logic [19:0] sb_cnt [0:31];
  logic [27:0] sb_addr [0:31];

  int checks = 0;
  int errors = 0;
  int stall_bad;
  logic b_ov_seen = 1'b0;

  heap_sift_stage #(.CNT_SIZE(20), .ADDR_SIZE(28), .TOTAL_LEVEL(6), .CURRENT_LEVEL(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(a_in_ready),
    .in_index(in_index), .in_cnt(in_cnt), .in_addr(in_addr), .in_path(in_path),
    .stored_cnt(sa_cnt), .stored_addr(sa_addr),
    .write_en(a_write_en), .write_index(a_write_index), .write_cnt(a_write_cnt), .write_addr(a_write_addr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_index(a_out_index), .out_cnt(a_out_cnt),
    .out_addr(a_out_addr), .out_path(a_out_path), .err_index(a_err), .evict_cnt(a_evict)
  );

  heap_sift_stage #(.CNT_SIZE(20), .ADDR_SIZE(28), .TOTAL_LEVEL(6), .CURRENT_LEVEL(6)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(b_in_ready),
    .in_index(in_index), .in_cnt(in_cnt), .in_addr(in_addr), .in_path(in_path),
    .stored_cnt(sb_cnt), .stored_addr(sb_addr),
    .write_en(b_write_en), .write_index(b_write_index), .write_cnt(b_write_cnt), .write_addr(b_write_addr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_index(b_out_index), .out_cnt(b_out_cnt),
    .out_addr(b_out_addr), .out_path(b_out_path), .err_index(b_err), .evict_cnt(b_evict)
  );

  // Level stores as the surrounding heap would keep them
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin sa_cnt[i] <= '0; sa_addr[i] <= '0; end
      for (int j = 0; j < 32; j++) begin sb_cnt[j] <= '0; sb_addr[j] <= '0; end
    end else begin
      if (a_write_en) begin
        sa_cnt[a_write_index[1:0]]  <= a_write_cnt;
        sa_addr[a_write_index[1:0]] <= a_write_addr;
      end
      if (b_write_en) begin
        sb_cnt[b_write_index[4:0]]  <= b_write_cnt;
        sb_addr[b_write_index[4:0]] <= b_write_addr;
      end
    end
  end

  always @(posedge clk) if (b_out_valid) b_ov_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; returns #1 after that edge (DUT in CMP when accepted)
  task automatic send(input bit to_b, input logic [5:0] idx, input logic [19:0] cnt,
                      input logic [27:0] addr, input logic [5:0] path);
    in_index = idx; in_cnt = cnt; in_addr = addr; in_path = path;
    if (to_b) vb = 1'b1; else va = 1'b1;
    tick();
    va = 1'b0; vb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_write_en", a_write_en, 0);
    check("rst_err", a_err, 0);
    check("rst_out_cnt", a_out_cnt, 0);
    check("rst_write_cnt", a_write_cnt, 0);
    check("rst_evict", b_evict, 0);

    // Empty slot: plain write, no forward
    send(0, 6'd2, 20'd5, 28'h55, 6'd0);
    check("empty_in_ready", a_in_ready, 0);
    check("empty_write_en", a_write_en, 1);
    check("empty_write_idx", a_write_index, 2);
    check("empty_write_cnt", a_write_cnt, 5);
    tick();
    check("empty_ready_back", a_in_ready, 1);
    check("empty_no_fwd", a_out_valid, 0);
    check("empty_write_done", a_write_en, 0);
    check("empty_store", sa_cnt[2], 5);

    // Slot 1 <- 9/0xA, then a larger element displaces it down the right branch
    send(0, 6'd1, 20'd9, 28'hA, 6'd0);
    tick();
    send(0, 6'd1, 20'd12, 28'hB, 6'b000100);
    check("swap_write_en", a_write_en, 1);
    check("swap_write_idx", a_write_index, 1);
    check("swap_write_cnt", a_write_cnt, 12);
    check("swap_write_addr", a_write_addr, 28'hB);
    tick();
    check("swap_out_valid", a_out_valid, 1);
    check("swap_out_index", a_out_index, 3);
    check("swap_out_cnt", a_out_cnt, 9);
    check("swap_out_addr", a_out_addr, 28'hA);
    check("swap_out_path", a_out_path, 6'b000100);
    check("swap_store", sa_cnt[1], 12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("swap_done_ready", a_in_ready, 1);
    check("swap_done_valid", a_out_valid, 0);

    // Tie: newcomer passes through unchanged; then a 10-cycle stall
    send(0, 6'd0, 20'd7, 28'h70, 6'd0);
    tick();
    send(0, 6'd0, 20'd7, 28'h77, 6'd0);
    check("tie_no_write", a_write_en, 0);
    tick();
    check("tie_out_index", a_out_index, 0);
    check("tie_out_cnt", a_out_cnt, 7);
    check("tie_out_addr", a_out_addr, 28'h77);
    in_index = 6'd3; in_cnt = 20'd99; in_addr = 28'h99; in_path = 6'd0;
    va = 1'b1;
    stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_out_valid !== 1'b1 || a_out_cnt !== 20'd7 || a_out_addr !== 28'h77 ||
          a_out_index !== 6'd0 || a_in_ready !== 1'b0 || a_write_en !== 1'b0) stall_bad++;
      tick();
    end
    va = 1'b0;
    check("stall_stable", stall_bad, 0);
    check("stall_still_valid", a_out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_released", a_in_ready, 1);
    check("stall_no_accept", sa_cnt[3], 0);

    // Tie with path bit set goes to the right child
    send(0, 6'd0, 20'd7, 28'h78, 6'b000100);
    tick();
    check("tie_r_out_index", a_out_index, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Smaller newcomer forwarded, store untouched
    send(0, 6'd2, 20'd3, 28'h33, 6'd0);
    check("less_no_write", a_write_en, 0);
    tick();
    check("less_out_index", a_out_index, 4);
    check("less_out_cnt", a_out_cnt, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("less_store", sa_cnt[2], 5);

    // Out-of-range index
    send(0, 6'd4, 20'd50, 28'h44, 6'd0);
    check("err_pulse", a_err, 1);
    check("err_in_ready", a_in_ready, 1);
    check("err_no_write", a_write_en, 0);
    tick();
    check("err_pulse_end", a_err, 0);
    check("err_no_fwd", a_out_valid, 0);

    // Last level: three displacements are evicted
    send(1, 6'd5, 20'd4, 28'h40, 6'd0);
    tick();
    send(1, 6'd5, 20'd10, 28'hB0, 6'd0);
    check("last_write_en", b_write_en, 1);
    tick();
    check("last_evict1", b_evict, 1);
    send(1, 6'd5, 20'd11, 28'hB1, 6'd0);
    tick();
    send(1, 6'd5, 20'd12, 28'hB2, 6'd0);
    tick();
    check("last_evict3", b_evict, 3);
    check("last_store", sb_cnt[5], 12);
    check("last_no_out_valid", b_ov_seen, 0);
    check("last_ready", b_in_ready, 1);

    // Reset in the middle of a compare suppresses the write
    send(0, 6'd3, 20'd8, 28'h88, 6'd0);
    check("cmp_write_pending", a_write_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cmp_write_en", a_write_en, 0);
    check("rst_cmp_in_ready", a_in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset while a forward is pending
    send(0, 6'd0, 20'd5, 28'h50, 6'd0);
    tick();
    send(0, 6'd0, 20'd9, 28'h90, 6'd0);
    tick();
    check("fwd_pending", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_fwd_valid", a_out_valid, 0);
    check("rst_fwd_cnt", a_out_cnt, 0);
    check("rst_fwd_addr", a_out_addr, 0);
    check("rst_fwd_index", a_out_index, 0);
    check("rst_fwd_wcnt", a_write_cnt, 0);
    check("rst_fwd_evict", b_evict, 0);
    check("rst_fwd_ready", a_in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", a_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
